// File: rtl/mm_resp_pkg.sv
// Shared types and constants for the matrix-multiply memory responder.
package mm_resp_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HDR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SEL_DIM = 2'd0;
  localparam logic [1:0] SEL_M1  = 2'd1;
  localparam logic [1:0] SEL_M2  = 2'd2;

  localparam int unsigned HDR_ROW1 = 0;
  localparam int unsigned HDR_K    = 1;
  localparam int unsigned HDR_COL2 = 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mm_resp_ram.sv
// Square matrix store: synchronous write, asynchronous read.
module mm_resp_ram #(
  parameter int unsigned W  = 20,
  parameter int unsigned AB = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AB-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AB-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << AB;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mm_mem_responder.sv
// Memory-side responder for the matrix-multiply engine: holds dims, M1, M2, captures R.
// Optional write-count/duplicate-write checking under MM_RESP_COUNT_CHECK_EN (adds cnt_err).
module mm_mem_responder
  import mm_resp_pkg::*;
#(
  parameter int unsigned N       = 20,
  parameter int unsigned DIM_MAX = 8,
  parameter int unsigned AW      = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           ld_en,
  input  logic [1:0]     ld_sel,
  input  logic [AW-1:0]  ld_i,
  input  logic [AW-1:0]  ld_j,
  input  logic [N-1:0]   ld_data,
  input  logic [N-1:0]   i,
  input  logic [N-1:0]   j,
  input  logic           read,
  input  logic           write,
  input  logic           index,
  input  logic           finish,
  input  logic [2*N-1:0] write_data,
  output logic [N-1:0]   read_data,
  input  logic [AW-1:0]  rb_i,
  input  logic [AW-1:0]  rb_j,
  output logic [2*N-1:0] rb_data,
  output logic           done,
  output logic [15:0]    wr_count,
  output logic           err
`ifdef MM_RESP_COUNT_CHECK_EN
  , output logic         cnt_err
`endif
);

  localparam int unsigned AB    = 2 * AW;
  localparam int unsigned DEPTH = DIM_MAX * DIM_MAX;

  state_t state_q, state_d;
  logic [N-1:0] row1, k_dim, col2;
  logic         done_d, err_d;
  logic [15:0]  wr_count_d;

  logic [AB-1:0] ld_addr, eng_addr, rb_addr;
  logic [N-1:0]  m1_q, m2_q;
  logic          m1_we, m2_we, r_we;
  logic          m1_ok, m2_ok, w_ok, dims_bad, run_wr;

  assign ld_addr  = {ld_i, ld_j};
  assign eng_addr = {i[AW-1:0], j[AW-1:0]};
  assign rb_addr  = {rb_i, rb_j};

  // Range checks use the full-width engine address.
  assign m1_ok    = (i < row1)  && (j < k_dim);
  assign m2_ok    = (i < k_dim) && (j < col2);
  assign w_ok     = (i < row1)  && (j < col2);
  assign dims_bad = (row1 == '0)  || (row1 > N'(DIM_MAX)) ||
                    (k_dim == '0) || (k_dim > N'(DIM_MAX)) ||
                    (col2 == '0)  || (col2 > N'(DIM_MAX));

  assign run_wr = (state_q == RUN) && write && !read;
  assign m1_we  = (state_q == LOAD) && ld_en && (ld_sel == SEL_M1);
  assign m2_we  = (state_q == LOAD) && ld_en && (ld_sel == SEL_M2);
  assign r_we   = run_wr && w_ok;

  mm_resp_ram #(.W(N), .AB(AB)) u_m1 (
    .clk(clk), .we(m1_we), .waddr(ld_addr), .wdata(ld_data),
    .raddr(eng_addr), .rdata(m1_q)
  );

  mm_resp_ram #(.W(N), .AB(AB)) u_m2 (
    .clk(clk), .we(m2_we), .waddr(ld_addr), .wdata(ld_data),
    .raddr(eng_addr), .rdata(m2_q)
  );

  mm_resp_ram #(.W(2*N), .AB(AB)) u_r (
    .clk(clk), .we(r_we), .waddr(eng_addr), .wdata(write_data),
    .raddr(rb_addr), .rdata(rb_data)
  );

  // Dimension header; matrices are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      row1  <= '0;
      k_dim <= '0;
      col2  <= '0;
    end else if ((state_q == LOAD) && ld_en && (ld_sel == SEL_DIM)) begin
      case (ld_i)
        AW'(HDR_ROW1): row1  <= ld_data;
        AW'(HDR_K):    k_dim <= ld_data;
        AW'(HDR_COL2): col2  <= ld_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      done     <= 1'b0;
      err      <= 1'b0;
      wr_count <= '0;
    end else begin
      state_q  <= state_d;
      done     <= done_d;
      err      <= err_d;
      wr_count <= wr_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    done_d     = done;
    err_d      = err;
    wr_count_d = wr_count;
    read_data  = '0;
    case (state_q)
      LOAD: begin
        if (start) begin
          state_d = HDR;
          if (dims_bad) err_d = 1'b1;
        end
      end
      HDR: begin
        if (i == N'(HDR_ROW1))      read_data = row1;
        else if (i == N'(HDR_K))    read_data = k_dim;
        else if (i == N'(HDR_COL2)) read_data = col2;
        if (read && (i == N'(HDR_COL2))) state_d = RUN;
      end
      RUN: begin
        if (read && !write) begin
          if (index) read_data = m2_ok ? m2_q : '0;
          else       read_data = m1_ok ? m1_q : '0;
        end
        if (run_wr) begin
          if (w_ok) wr_count_d = sat_inc16(wr_count);
          else      err_d      = 1'b1;
        end
        // A same-cycle write has already been folded in above.
        if (finish) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: ;
      default: state_d = LOAD;
    endcase
  end

`ifdef MM_RESP_COUNT_CHECK_EN
  logic [DEPTH-1:0] written;
  logic [2*N-1:0]   exp_writes;

  assign exp_writes = (2*N)'(row1) * (2*N)'(col2);

  // Flags a short/long write count at finish and any repeated write to one R entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      written <= '0;
      cnt_err <= 1'b0;
    end else begin
      if ((state_q == LOAD) && start) written <= '0;
      else if (r_we)                  written[eng_addr] <= 1'b1;
      if (r_we && written[eng_addr]) cnt_err <= 1'b1;
      if ((state_q == RUN) && finish && ((2*N)'(wr_count_d) != exp_writes)) cnt_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_mem_responder.sv
// Scoreboard bench for mm_mem_responder: stimulus queues expectations, a negedge monitor checks them.
module tb_mm_mem_responder;

  localparam int N  = 20;
  localparam int AW = 3;

  logic           clk = 1'b0;
  logic           reset, start, ld_en, read, write, index, finish;
  logic [1:0]     ld_sel;
  logic [AW-1:0]  ld_i, ld_j, rb_i, rb_j;
  logic [N-1:0]   ld_data, i, j, read_data;
  logic [2*N-1:0] write_data, rb_data;
  logic           done, err;
  logic [15:0]    wr_count;

  mm_mem_responder #(.N(N), .DIM_MAX(8), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .ld_en(ld_en), .ld_sel(ld_sel),
    .ld_i(ld_i), .ld_j(ld_j), .ld_data(ld_data), .i(i), .j(j),
    .read(read), .write(write), .index(index), .finish(finish),
    .write_data(write_data), .read_data(read_data), .rb_i(rb_i), .rb_j(rb_j),
    .rb_data(rb_data), .done(done), .wr_count(wr_count), .err(err)
  );

  always #5 clk = ~clk;

  localparam int S_RD = 0, S_RB = 1, S_DONE = 2, S_CNT = 3, S_ERR = 4;

  typedef struct {
    string       name;
    int          sig;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: everything queued since the last negedge is checked against live outputs.
  initial begin
    exp_t        e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sig)
          S_RD:    act = 64'(read_data);
          S_RB:    act = 64'(rb_data);
          S_DONE:  act = 64'(done);
          S_CNT:   act = 64'(wr_count);
          default: act = 64'(err);
        endcase
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int s, input logic [63:0] e);
    exp_t x;
    x.name = nm;
    x.sig  = s;
    x.exp  = e;
    q.push_back(x);
  endtask

  task automatic ld(input logic [1:0] sel, input int a, input int b, input int d);
    ld_en = 1'b1; ld_sel = sel; ld_i = AW'(a); ld_j = AW'(b); ld_data = N'(d);
    step();
    ld_en = 1'b0;
  endtask

  task automatic load_dims(input int r, input int k, input int c);
    ld(2'd0, 0, 0, r);
    ld(2'd0, 1, 0, k);
    ld(2'd0, 2, 0, c);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic hdr_seq(input int r, input int k, input int c);
    read = 1'b1; write = 1'b1;
    i = N'(0); chk("hdr_row1", S_RD, 64'(r)); step();
    i = N'(1); chk("hdr_k",    S_RD, 64'(k)); step();
    i = N'(2); chk("hdr_col2", S_RD, 64'(c)); step();
    read = 1'b0; write = 1'b0; i = '0;
  endtask

  task automatic rd(input string nm, input logic idx, input int a, input int b, input int e);
    read = 1'b1; index = idx; i = N'(a); j = N'(b);
    chk(nm, S_RD, 64'(e));
    step();
    read = 1'b0;
  endtask

  task automatic wr(input int a, input int b, input int d, input logic fin);
    write = 1'b1; finish = fin; i = N'(a); j = N'(b); write_data = (2*N)'(d);
    step();
    write = 1'b0; finish = 1'b0;
  endtask

  task automatic rb(input string nm, input int a, input int b, input int e);
    rb_i = AW'(a); rb_j = AW'(b);
    chk(nm, S_RB, 64'(e));
    step();
  endtask

  int m1 [2][3] = '{'{1, 2, 3}, '{4, 5, 6}};
  int m2 [3][2] = '{'{7, 8}, '{9, 10}, '{11, 12}};

  initial begin
    reset = 1'b1; start = 0; ld_en = 0; ld_sel = '0; ld_i = '0; ld_j = '0;
    ld_data = '0; i = '0; j = '0; read = 0; write = 0; index = 0; finish = 0;
    write_data = '0; rb_i = '0; rb_j = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_done", S_DONE, 0);
    chk("rst_cnt",  S_CNT,  0);
    chk("rst_err",  S_ERR,  0);
    chk("rst_rd",   S_RD,   0);
    step();

    load_dims(2, 3, 2);
    for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) ld(2'd1, r, c, m1[r][c]);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 2; c++) ld(2'd2, r, c, m2[r][c]);
    ld(2'd3, 0, 0, 77);
    rd("load_rd_ignored", 1'b0, 1, 1, 0);

    pulse_start();
    chk("start_ok_err", S_ERR, 0);
    hdr_seq(2, 3, 2);

    rd("m1_1_2", 1'b0, 1, 2, 6);
    rd("m2_2_1", 1'b1, 2, 1, 12);
    rd("m1_0_0", 1'b0, 0, 0, 1);
    rd("m1_overrun", 1'b0, 0, 3, 0);
    rd("m2_oob_row", 1'b1, 3, 0, 0);
    rd("m2_wide_j", 1'b1, 0, 32'h10000, 0);
    chk("oob_rd_err", S_ERR, 0);

    wr(0, 0, 58, 1'b0);
    wr(0, 1, 64, 1'b0);
    wr(1, 0, 139, 1'b0);
    chk("cnt3", S_CNT, 3);
    chk("err_clean", S_ERR, 0);
    read = 1'b1; write = 1'b1; i = '0; j = '0; write_data = (2*N)'(5);
    chk("rw_noop_rd", S_RD, 0);
    step();
    read = 1'b0; write = 1'b0;
    chk("rw_noop_cnt", S_CNT, 3);

    wr(2, 0, 999, 1'b0);
    chk("bad_wr_err", S_ERR, 1);
    chk("bad_wr_cnt", S_CNT, 3);
    step();

    wr(1, 1, 154, 1'b1);
    chk("fin_done", S_DONE, 1);
    chk("fin_cnt",  S_CNT,  4);
    step();
    wr(0, 0, 999, 1'b0);
    chk("done_wr_cnt", S_CNT, 4);
    rd("done_rd", 1'b0, 0, 0, 0);

    rb("r00", 0, 0, 58);
    rb("r01", 0, 1, 64);
    rb("r10", 1, 0, 139);
    rb("r11", 1, 1, 154);

    // Reset mid-RUN, then verify dims cleared and matrices retained.
    do_reset();
    load_dims(2, 3, 2);
    pulse_start();
    hdr_seq(2, 3, 2);
    wr(0, 0, 58, 1'b0);
    chk("mid_cnt", S_CNT, 1);
    step();
    do_reset();
    chk("mr_done", S_DONE, 0);
    chk("mr_cnt",  S_CNT,  0);
    chk("mr_err",  S_ERR,  0);
    step();
    pulse_start();
    chk("zero_dims_err", S_ERR, 1);
    read = 1'b1; write = 1'b1; i = '0;
    chk("cleared_row1", S_RD, 0);
    step();
    read = 1'b0; write = 1'b0;

    do_reset();
    load_dims(2, 3, 9);
    pulse_start();
    chk("col2_9_err", S_ERR, 1);
    step();

    do_reset();
    load_dims(2, 3, 2);
    pulse_start();
    chk("reload_err", S_ERR, 0);
    hdr_seq(2, 3, 2);
    rd("kept_m1_1_0", 1'b0, 1, 0, 4);
    rd("kept_m2_2_1", 1'b1, 2, 1, 12);
    rb("kept_r11", 1, 1, 154);

    for (int w = 0; w < 20 && q.size() > 0; w++) step();
    if (q.size() > 0) begin
      $display("FAIL drain: %0d pending expected 0", q.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
